rr_arbiter8: RTL and testbench
==============================

// Module: rr_arbiter8
//
// PURPOSE
//   Round-robin arbiter that shares one resource between eight requesters.
//   SEL drives the select input of the 8-way 1-bit demultiplexer fabric
//   (encoding 000=A ... 111=H), so the resource's load/strobe reaches only
//   the current owner. GRANT is the one-hot form of the same decision.
//   A hold limit stops a requester that never releases from starving the others.
//
// PARAMETERS
//   HOLD_MAX  16  max consecutive GRANT cycles per ownership; 0 = unlimited
//   CNT_W     8   hold counter width; HOLD_MAX <= 2**CNT_W-1 is required
//
// PORTS
//   CLK      in   1  clock, rising edge
//   RESET_N  in   1  asynchronous reset, active low
//   ENABLE   in   1  1 = new grants allowed; 0 = current ownership runs to its end
//   REQ      in   8  request per requester; bit i = requester i (A=0 ... H=7)
//   GRANT    out  8  one-hot owner, registered; all zero when no owner
//   SEL      out  3  binary index of owner, registered; holds last owner when idle
//   BUSY     out  1  1 while a grant is active (equals |GRANT)
//   EXPIRED  out  1  one-cycle pulse: the last ownership ended at HOLD_MAX
//
// BEHAVIOUR
//   Reset, asynchronous while RESET_N=0: state IDLE, GRANT=0, SEL=0, BUSY=0,
//     EXPIRED=0, PTR=7, CNT=0. Because PTR=7, requester 0 has top priority first.
//   State IDLE: GRANT=0. If ENABLE=1 and REQ!=0, the winner is the first set
//     REQ bit found scanning PTR+1, PTR+2 ... modulo 8. At the next edge:
//     GRANT=onehot(w), SEL=w, BUSY=1, CNT=1, state OWN. Latency from REQ to GRANT
//     is 1 cycle. Otherwise the block stays in IDLE.
//   State OWN, owner w. Evaluated at each edge:
//     - REQ[w]=0: go to IDLE, GRANT=0, BUSY=0, PTR=w, EXPIRED=0.
//     - REQ[w]=1 and HOLD_MAX!=0 and CNT==HOLD_MAX: go to IDLE, GRANT=0, BUSY=0,
//       PTR=w, EXPIRED=1 for exactly one cycle.
//     - Otherwise: stay in OWN; CNT increments and saturates at 2**CNT_W-1.
//   EXPIRED is 0 in every cycle except the one after a forced release.
//   Between two grants there is always at least one cycle with GRANT=0.
//     This gap lets the downstream demux and strobe settle.
//   Fairness: the owner that just released becomes lowest priority. Any steady
//     requester is granted within 7 ownerships.
//   ENABLE=0 during OWN has no effect on the current owner. ENABLE only gates
//     new grants from IDLE.
//   Requests from non-owners are ignored while in OWN, and are not latched.
//   REQ bits are sampled as level; the requester holds REQ until granted.
//   SEL changes only on a new grant. SEL never changes while BUSY=1.
//   Hard invariants: GRANT is zero or one-hot; GRANT[SEL]==BUSY.
//   Reset asserted mid-ownership: GRANT and BUSY drop immediately, no pulse.
//
// TESTING
//   1. Reset, then REQ=8'h01 -> GRANT=8'h01, SEL=0 one cycle later.
//      Drop REQ -> GRANT=0 next cycle, PTR=0.
//   2. REQ=8'hFF held, HOLD_MAX=0, each owner drops REQ after 2 cycles ->
//      grant order 0,1,...,7,0 with one idle cycle between grants.
//   3. HOLD_MAX=4, REQ=8'h08 never dropped -> GRANT=8'h08 for exactly 4 cycles,
//      then GRANT=0 with EXPIRED=1 for 1 cycle, then regranted to 3.
//   4. Owner 5 active, REQ=8'h21 -> no change while 5 holds.
//      Release 5 -> grant goes to 0 (wrap-around from PTR=5).
//   5. ENABLE=0 with REQ=8'h10 -> no grant. Set ENABLE=1 -> GRANT=8'h10 next cycle.
//      Owner active and ENABLE=0 -> ownership continues.
//   6. RESET_N pulsed low mid-ownership (GRANT=8'h40) -> GRANT=0, SEL=0 at once.
//      After release, REQ=8'hC0 -> requester 6 wins (PTR=7).

Source files
------------

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-way round-robin arbiter with a per-ownership hold limit.
// grant is the one-hot owner, sel its binary index for the demux fabric.
// A forced release at the hold limit is flagged by a one-cycle expired pulse.
module rr_arbiter8 #(
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       busy,
  output logic       expired
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] cnt;
  logic             win_found;
  logic [2:0]       win_idx;
  logic [2:0]       scan_idx;

  // Find the first requester after the last owner, wrapping modulo 8
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr;
    scan_idx  = '0;
    for (int k = 1; k <= 8; k++) begin
      scan_idx = ptr + 3'(k);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Ownership state machine; every output is registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      grant   <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      expired <= 1'b0;
      ptr     <= 3'd7;
      cnt     <= '0;
    end else begin
      expired <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable && win_found) begin
            state <= ST_OWN;
            grant <= 8'b1 << win_idx;
            sel   <= win_idx;
            busy  <= 1'b1;
            cnt   <= CNT_W'(1);
          end
        end
        ST_OWN: begin
          if (!req[sel]) begin
            state <= ST_IDLE;
            grant <= '0;
            busy  <= 1'b0;
            ptr   <= sel;
          end else if ((HOLD_MAX != 0) && (cnt == CNT_W'(HOLD_MAX))) begin
            state   <= ST_IDLE;
            grant   <= '0;
            busy    <= 1'b0;
            ptr     <= sel;
            expired <= 1'b1;
          end else if (cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: scoreboard bench for rr_arbiter8 with a behavioural model.
// The driver pushes the model's post-edge outputs; a monitor pops and compares.
module tb_rr_arbiter8;

  localparam int HOLD = 4;

  typedef struct packed {
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic       expired;
  } out_t;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       busy;
  logic       expired;

  out_t exp_q[$];
  int   check_count;
  int   error_count;

  // Model state: owner index (-1 = none), last owner, hold length, last sel
  int   m_owner;
  int   m_ptr;
  int   m_cnt;
  int   m_sel;
  logic m_exp;

  rr_arbiter8 #(.HOLD_MAX(HOLD), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .req     (req),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .expired (expired)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int pick_winner(input int p, input logic [7:0] r);
    for (int k = 1; k <= 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input out_t want);
    out_t got;
    got = '{grant: grant, sel: sel, busy: busy, expired: expired};
    check_count++;
    if (got !== want) begin
      error_count++;
      $display("[TB] FAIL %s at %0t: got grant=%h sel=%0d busy=%b expired=%b, expected grant=%h sel=%0d busy=%b expired=%b",
               name, $time, got.grant, got.sel, got.busy, got.expired,
               want.grant, want.sel, want.busy, want.expired);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the expected outcome
  task automatic applyStimulus(input logic rstn_v, input logic en_v, input logic [7:0] req_v);
    int w;
    out_t e;
    @(negedge clk);
    rst_n  = rstn_v;
    enable = en_v;
    req    = req_v;
    if (!rstn_v) begin
      m_owner = -1;
      m_ptr   = 7;
      m_cnt   = 0;
      m_sel   = 0;
      m_exp   = 1'b0;
    end else begin
      m_exp = 1'b0;
      if (m_owner < 0) begin
        w = pick_winner(m_ptr, req_v);
        if (en_v && w >= 0) begin
          m_owner = w;
          m_sel   = w;
          m_cnt   = 1;
        end
      end else if (!req_v[m_owner]) begin
        m_ptr   = m_owner;
        m_owner = -1;
      end else if (HOLD != 0 && m_cnt == HOLD) begin
        m_ptr   = m_owner;
        m_owner = -1;
        m_exp   = 1'b1;
      end else if (m_cnt < 255) begin
        m_cnt++;
      end
    end
    e.grant   = (m_owner < 0) ? 8'h00 : (8'h01 << m_owner);
    e.sel     = 3'(m_sel);
    e.busy    = (m_owner >= 0);
    e.expired = m_exp;
    exp_q.push_back(e);
    if (!rstn_v) begin
      #1;
      checkOutput("reset_immediate", '{grant: 8'h00, sel: 3'd0, busy: 1'b0, expired: 1'b0});
    end
  endtask

  // Monitor: just after each rising edge, pop and compare one expectation
  initial begin
    out_t want;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        checkOutput("scoreboard", want);
      end
    end
  end

  // Directed scenarios followed by randomized traffic
  initial begin
    logic [7:0] cur_req;
    int wait_cycles;
    check_count = 0;
    error_count = 0;
    m_owner = -1; m_ptr = 7; m_cnt = 0; m_sel = 0; m_exp = 1'b0;
    rst_n = 1'b0; enable = 1'b0; req = 8'h00;

    repeat (2) applyStimulus(1'b0, 1'b0, 8'h00);

    // single requester 0, then release
    applyStimulus(1'b1, 1'b1, 8'h01);
    applyStimulus(1'b1, 1'b1, 8'h01);
    applyStimulus(1'b1, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h00);

    // all requesting, each owner drops after two cycles: rotation 1..7,0,1
    for (int g = 1; g <= 9; g++) begin
      applyStimulus(1'b1, 1'b1, 8'hFF);
      applyStimulus(1'b1, 1'b1, 8'hFF);
      applyStimulus(1'b1, 1'b1, 8'hFF & ~(8'h01 << (g % 8)));
    end
    applyStimulus(1'b1, 1'b1, 8'h00);

    // never-releasing requester 3 hits the hold limit and is regranted
    repeat (12) applyStimulus(1'b1, 1'b1, 8'h08);
    applyStimulus(1'b1, 1'b1, 8'h00);

    // owner 5 ignores requester 0 until it releases, then wrap to 0
    applyStimulus(1'b1, 1'b1, 8'h20);
    repeat (2) applyStimulus(1'b1, 1'b1, 8'h21);
    applyStimulus(1'b1, 1'b1, 8'h01);
    applyStimulus(1'b1, 1'b1, 8'h01);
    applyStimulus(1'b1, 1'b1, 8'h00);

    // enable gates only new grants
    repeat (2) applyStimulus(1'b1, 1'b0, 8'h10);
    applyStimulus(1'b1, 1'b1, 8'h10);
    repeat (2) applyStimulus(1'b1, 1'b0, 8'h10);
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'h00);

    // reset mid-ownership of 6, then 6 wins again from pointer 7
    applyStimulus(1'b1, 1'b1, 8'h40);
    applyStimulus(1'b1, 1'b1, 8'h40);
    applyStimulus(1'b0, 1'b1, 8'h40);
    applyStimulus(1'b1, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'hC0);
    applyStimulus(1'b1, 1'b1, 8'hC0);
    applyStimulus(1'b1, 1'b1, 8'h00);

    // random traffic: slowly changing request levels, rare resets
    cur_req = 8'h00;
    for (int i = 0; i < 500; i++) begin
      cur_req = cur_req ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      applyStimulus(($urandom_range(0, 99) != 0), ($urandom_range(0, 3) != 0), cur_req);
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      check_count++;
      error_count++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
